// File: rtl/gesture_matcher.sv
// Gesture matcher: scores one encoder stroke against every stored direction template
// and reports the lowest-distance template, its score and whether it counts as a hit.
module gesture_matcher #(
    parameter int N_TPL  = 8,
    parameter int IDX_W  = 3,
    parameter int THRESH = 2
) (
    input  logic             iclk,
    input  logic             i_rst,
    input  logic             i_send,
    input  logic [5:0]       i_data_len,
    input  logic [255:0]     i_data,
    input  logic             i_tpl_we,
    input  logic [IDX_W-1:0] i_tpl_sel,
    input  logic [5:0]       i_tpl_len,
    input  logic [255:0]     i_tpl_data,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_match_idx,
    output logic [8:0]       o_score
);

    typedef enum logic [2:0] {IDLE, LOAD, TPL_INIT, COMPARE, ADVANCE, NEXT, DONE} state_t;

    state_t state, state_next;

    logic             send_q;
    logic             start;
    logic [5:0]       tpl_len [N_TPL];
    logic [255:0]     tpl_mem [N_TPL];

    logic [5:0]       len;
    logic [255:0]     data;
    logic [IDX_W-1:0] t;
    logic [5:0]       k;
    logic [5:0]       j;
    logic [6:0]       r;
    logic [8:0]       score;
    logic [8:0]       best_score;
    logic [IDX_W-1:0] best_idx;
    logic             found;
    logic             evaluated;

    logic [5:0]       cur_len;
    logic [255:0]     cur_tpl;
    logic             last_tpl;
    logic             skip_tpl;
    logic [6:0]       r_sum;
    logic [6:0]       r_sub;
    logic [3:0]       elem_dist;
    logic [8:0]       score_sum;
    logic             better;
    logic [8:0]       final_score;
    logic [IDX_W-1:0] final_idx;
    logic             final_found;
    logic [8:0]       thresh_l;

    // Circular distance between two of the 16 compass directions, 0..8.
    function automatic logic [3:0] dir_dist(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = a - b;
        return (d > 4'd8) ? 4'(5'd16 - {1'b0, d}) : d;
    endfunction

    assign start    = i_send && !send_q && (state == IDLE);
    assign o_busy   = (state != IDLE);
    assign o_valid  = (state == DONE);

    assign cur_len   = tpl_len[t];
    assign cur_tpl   = tpl_mem[t];
    assign last_tpl  = (32'(t) == N_TPL - 1);
    assign skip_tpl  = (cur_len == 6'd0) || (len == 6'd0);
    assign r_sum     = r + {1'b0, cur_len};
    assign r_sub     = r - {1'b0, len};
    assign elem_dist = dir_dist(data[{k, 2'b00} +: 4], cur_tpl[{j, 2'b00} +: 4]);
    assign score_sum = score + {5'b0, elem_dist};

    // Strict less-than keeps the lower-numbered template on ties.
    assign better      = evaluated && (score < best_score);
    assign final_score = better ? score : best_score;
    assign final_idx   = better ? t : best_idx;
    assign final_found = found || better;
    assign thresh_l    = 9'(THRESH) * {3'b0, len};

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state  <= IDLE;
            send_q <= 1'b0;
        end else begin
            state  <= state_next;
            send_q <= i_send;
        end
    end

    // The remainder r tracks k*T mod L, so j advances exactly floor(k*T/L) without a divider.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = LOAD;
            LOAD:     state_next = TPL_INIT;
            TPL_INIT: state_next = skip_tpl ? NEXT : COMPARE;
            COMPARE: begin
                if (6'(k + 6'd1) == len)
                    state_next = NEXT;
                else if (r_sum >= {1'b0, len})
                    state_next = ADVANCE;
                else
                    state_next = COMPARE;
            end
            ADVANCE:  if (r_sub < {1'b0, len}) state_next = COMPARE;
            NEXT:     state_next = last_tpl ? DONE : TPL_INIT;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            for (int i = 0; i < N_TPL; i++) tpl_len[i] <= 6'd0;
        end else if ((state == IDLE) && !start && i_tpl_we && (32'(i_tpl_sel) < N_TPL)) begin
            tpl_len[i_tpl_sel] <= i_tpl_len;
            tpl_mem[i_tpl_sel] <= i_tpl_data;
        end
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            len         <= 6'd0;
            data        <= '0;
            t           <= '0;
            k           <= 6'd0;
            j           <= 6'd0;
            r           <= 7'd0;
            score       <= 9'd0;
            best_score  <= 9'd0;
            best_idx    <= '0;
            found       <= 1'b0;
            evaluated   <= 1'b0;
            o_hit       <= 1'b0;
            o_match_idx <= '0;
            o_score     <= 9'd0;
        end else begin
            case (state)
                LOAD: begin
                    len        <= i_data_len;
                    data       <= i_data;
                    t          <= '0;
                    best_score <= 9'd511;
                    best_idx   <= '0;
                    found      <= 1'b0;
                end
                TPL_INIT: begin
                    k         <= 6'd0;
                    j         <= 6'd0;
                    r         <= 7'd0;
                    score     <= 9'd0;
                    evaluated <= !skip_tpl;
                end
                COMPARE: begin
                    score <= score_sum;
                    r     <= r_sum;
                    k     <= k + 6'd1;
                end
                ADVANCE: begin
                    r <= r_sub;
                    j <= j + 6'd1;
                end
                NEXT: begin
                    if (better) begin
                        best_score <= score;
                        best_idx   <= t;
                        found      <= 1'b1;
                    end
                    // Results are loaded on the way into DONE so they are stable while o_valid is high.
                    if (last_tpl) begin
                        o_score     <= final_score;
                        o_match_idx <= final_idx;
                        o_hit       <= final_found && (final_score <= thresh_l);
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_matcher.sv
// Scoreboard bench for gesture_matcher: directed strokes push expected results,
// an independent monitor pops and compares on every o_valid pulse.
module tb_gesture_matcher;

    localparam int IDX_W = 3;

    logic             iclk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_send = 1'b0;
    logic [5:0]       i_data_len = '0;
    logic [255:0]     i_data = '0;
    logic             i_tpl_we = 1'b0;
    logic [IDX_W-1:0] i_tpl_sel = '0;
    logic [5:0]       i_tpl_len = '0;
    logic [255:0]     i_tpl_data = '0;
    logic             o_busy;
    logic             o_valid;
    logic             o_hit;
    logic [IDX_W-1:0] o_match_idx;
    logic [8:0]       o_score;

    typedef struct packed {
        logic [8:0]       score;
        logic [IDX_W-1:0] idx;
        logic             hit;
    } result_t;

    result_t sb[$];
    int checks = 0;
    int passes = 0;

    gesture_matcher #(.N_TPL(8), .IDX_W(IDX_W), .THRESH(2)) dut (
        .iclk        (iclk),
        .i_rst       (i_rst),
        .i_send      (i_send),
        .i_data_len  (i_data_len),
        .i_data      (i_data),
        .i_tpl_we    (i_tpl_we),
        .i_tpl_sel   (i_tpl_sel),
        .i_tpl_len   (i_tpl_len),
        .i_tpl_data  (i_tpl_data),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_hit       (o_hit),
        .o_match_idx (o_match_idx),
        .o_score     (o_score)
    );

    initial forever #5 iclk = ~iclk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge iclk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_valid", 1, 0);
            end else begin
                result_t e;
                e = sb.pop_front();
                check_output("score", int'(o_score), int'(e.score));
                check_output("match_idx", int'(o_match_idx), int'(e.idx));
                check_output("hit", int'(o_hit), int'(e.hit));
            end
        end
    end

    task automatic apply_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge iclk);
        i_rst = 1'b0;
    endtask

    task automatic write_tpl(input int slot, input int len, input logic [255:0] tdata);
        i_tpl_we   = 1'b1;
        i_tpl_sel  = IDX_W'(slot);
        i_tpl_len  = 6'(len);
        i_tpl_data = tdata;
        @(negedge iclk);
        i_tpl_we   = 1'b0;
    endtask

    task automatic apply_stimulus(input int len, input logic [255:0] sdata,
                                  input int exp_score, input int exp_idx, input int exp_hit,
                                  output int cycles);
        result_t e;
        e.score = 9'(exp_score);
        e.idx   = IDX_W'(exp_idx);
        e.hit   = 1'(exp_hit);
        sb.push_back(e);
        i_data_len = 6'(len);
        i_data     = sdata;
        i_send     = 1'b1;
        cycles     = 0;
        do begin
            @(negedge iclk);
            cycles++;
            i_send = 1'b0;
        end while (!o_valid && cycles < 500);
        if (!o_valid) check_output("result_timeout", 0, 1);
        @(negedge iclk);
    endtask

    int lat;
    int nvalid;

    initial begin
        apply_reset();
        check_output("reset_busy", int'(o_busy), 0);
        check_output("reset_valid", int'(o_valid), 0);
        check_output("reset_hit", int'(o_hit), 0);
        check_output("reset_score", int'(o_score), 0);
        check_output("reset_idx", int'(o_match_idx), 0);

        // Exact match on slot 0
        write_tpl(0, 6, 256'h543210);
        apply_stimulus(6, 256'h543210, 0, 0, 1, lat);
        check_output("latency_exact", lat, 29);

        // Wrap-around distance and threshold
        write_tpl(0, 6, 256'h0);
        apply_stimulus(6, 256'hFFFFFF, 6, 0, 1, lat);
        check_output("latency_wrap", lat, 29);
        apply_stimulus(6, 256'h888888, 48, 0, 0, lat);

        // Resampling against a shorter template in slot 2
        write_tpl(2, 3, 256'h840);
        apply_stimulus(6, 256'h884400, 0, 2, 1, lat);
        check_output("latency_resample6", lat, 37);
        apply_stimulus(2, 256'h80, 4, 2, 1, lat);
        check_output("latency_resample2", lat, 26);

        // Tie-break and near-miss
        apply_reset();
        write_tpl(1, 6, 256'h543210);
        write_tpl(3, 6, 256'h543210);
        write_tpl(5, 6, 256'h643210);
        apply_stimulus(6, 256'h543210, 0, 1, 1, lat);
        check_output("latency_tie", lat, 51);

        // Held send level gives exactly one run
        begin
            result_t e;
            e.score = 9'd0; e.idx = IDX_W'(1); e.hit = 1'b1;
            sb.push_back(e);
        end
        i_send = 1'b1;
        nvalid = 0;
        repeat (100) begin
            @(negedge iclk);
            if (o_valid) nvalid++;
        end
        i_send = 1'b0;
        check_output("held_send_runs", nvalid, 1);

        // Second edge and template write while busy are both ignored
        begin
            result_t e;
            e.score = 9'd0; e.idx = IDX_W'(1); e.hit = 1'b1;
            sb.push_back(e);
        end
        i_send = 1'b1;
        @(negedge iclk);
        i_send = 1'b0;
        repeat (4) @(negedge iclk);
        i_send     = 1'b1;
        i_tpl_we   = 1'b1;
        i_tpl_sel  = IDX_W'(1);
        i_tpl_len  = 6'd6;
        i_tpl_data = 256'hFFFFFF;
        @(negedge iclk);
        i_send   = 1'b0;
        i_tpl_we = 1'b0;
        nvalid = 0;
        repeat (120) begin
            @(negedge iclk);
            if (o_valid) nvalid++;
        end
        check_output("busy_edge_runs", nvalid, 1);
        apply_stimulus(6, 256'h543210, 0, 1, 1, lat);

        // Empty stroke
        apply_stimulus(0, 256'h543210, 511, 0, 0, lat);
        check_output("latency_empty", lat, 18);

        // Reset in the middle of a comparison
        i_data_len = 6'd6;
        i_data     = 256'h543210;
        i_send     = 1'b1;
        @(negedge iclk);
        i_send = 1'b0;
        repeat (4) @(negedge iclk);
        check_output("busy_before_reset", int'(o_busy), 1);
        i_rst = 1'b1;
        @(negedge iclk);
        check_output("busy_after_reset", int'(o_busy), 0);
        check_output("valid_after_reset", int'(o_valid), 0);
        i_rst = 1'b0;
        nvalid = 0;
        repeat (60) begin
            @(negedge iclk);
            if (o_valid) nvalid++;
        end
        check_output("aborted_run_valids", nvalid, 0);
        apply_stimulus(6, 256'h543210, 511, 0, 0, lat);
        check_output("latency_no_tpl", lat, 18);

        repeat (3) @(negedge iclk);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
